mem_arb: RTL and testbench
==========================

MEM_ARB -- requirements
Module: mem_arb

Interface
REQ-001 clk  in  1  system clock; all state updates on rising edge.
REQ-002 rst  in  1  asynchronous, active-high reset.
REQ-003 i_rd, i_wr  in  1 each  instruction-side read / write request.
REQ-004 i_addr, i_data  in  16 each  instruction-side address / write data.
REQ-005 i_lock  in  1  instruction side requests exclusive ownership (line fill / writeback burst).
REQ-006 i_gnt  out  1  instruction request issued to memory this cycle.
REQ-007 i_rvalid, i_rdata  out  1, 16  read-return pulse and data for instruction side.
REQ-008 d_rd, d_wr, d_addr, d_data, d_lock, d_gnt, d_rvalid, d_rdata: same as REQ-003..007 for data side.
REQ-009 mem_rd, mem_wr  out  1 each  memory read / write strobe.
REQ-010 mem_addr, mem_data_in  out  16 each  address / write data to memory.
REQ-011 mem_data_out  in  16  memory read data.
REQ-012 busy  in  4  per-bank busy; bank of an address = addr[2:1].
REQ-013 err  out  1  high while any requester drives rd and wr together.

Function
REQ-014 Requester eligible: exactly one of rd/wr high, busy[addr[2:1]]==0, and not excluded by ownership state.
REQ-015 Ownership FSM states: IDLE, LOCK_I, LOCK_D.
REQ-016 IDLE: both sides may be granted; when the winner is granted with its lock high, next state is LOCK_I/LOCK_D.
REQ-017 LOCK_x: only x eligible; other side never granted; return to IDLE at the edge where x_lock samples 0.
REQ-018 Grant is combinational: at most one gnt per cycle; gnt=1 means mem_rd/mem_wr, mem_addr, mem_data_in carry the winner's request in the same cycle.
REQ-019 No eligible requester: mem_rd=mem_wr=0, gnt=0, mem_addr/mem_data_in = 0.
REQ-020 Ineligible requests stay pending unchanged; the arbiter holds no request state.
REQ-021 Rd&wr request: never granted, err=1 that cycle, other side arbitrated normally.
REQ-022 Read return: 2-stage pipeline of {valid, id}; read issued in cycle t gives x_rvalid=1 for exactly one cycle in t+2 with x_rdata=mem_data_out.
REQ-023 x_rdata = mem_data_out at all times; only rvalid qualifies it.
REQ-024 Writes produce no rvalid.
REQ-025 Back-to-back reads to different banks: one rvalid per cycle, in issue order, routed by stored id.
REQ-026 Tie, both eligible in IDLE: winner set by REQ-032.
REQ-027 last_gnt register records side of most recent grant and updates on every grant.

Reset
REQ-028 rst asserted: state=IDLE, return pipeline cleared, last_gnt=D, all strobes/gnt/rvalid/err=0 during reset.
REQ-029 rst mid-burst or with reads in flight: no rvalid produced for pre-reset reads after reset deasserts.
REQ-030 First cycle after reset deassert: normal arbitration; no cycle of dead time.

Configuration
REQ-031 Macro ARB_RR_EN selects tie-break policy.
REQ-032 ARB_RR_EN defined: tie granted to side opposite last_gnt (round robin); undefined: tie always granted to D; last_gnt still maintained, unused.

Verification
REQ-033 After reset, i_rd addr 0x0010, busy=0 -> i_gnt=1, mem_rd=1, mem_addr=0x0010 same cycle; i_rvalid=1 two cycles later with i_rdata=mem_data_out; d_rvalid stays 0.
REQ-034 Tie, both rd, different banks, ARB_RR_EN defined, held 4 cycles -> grants I,D,I,D; undefined -> D,D,D,D.
REQ-035 d_lock=1 with d_rd at 0x0000, 0x0002, 0x0004, 0x0006 while i_rd pending -> four d_gnt, zero i_gnt; i_gnt=1 in first IDLE cycle after d_lock sampled 0.
REQ-036 i_wr addr 0x0004 with busy=4'b0100 -> i_gnt=0, mem_wr=0; busy cleared -> i_gnt=1, mem_wr=1, mem_data_in=i_data; no i_rvalid.
REQ-037 d_rd and d_wr both high -> err=1, d_gnt=0; concurrent i_rd granted.
REQ-038 rst pulsed one cycle after a read issue -> no rvalid afterwards, state IDLE, last_gnt=D.

Source files
------------

// File: rtl/mem_arb_if.sv
// Request/grant/return bundle between the two requesters, the arbiter and memory.
// The arbiter takes the slave view; requesters and memory take the master view.
interface mem_arb_if;
    logic        i_rd;
    logic        i_wr;
    logic [15:0] i_addr;
    logic [15:0] i_data;
    logic        i_lock;
    logic        i_gnt;
    logic        i_rvalid;
    logic [15:0] i_rdata;
    logic        d_rd;
    logic        d_wr;
    logic [15:0] d_addr;
    logic [15:0] d_data;
    logic        d_lock;
    logic        d_gnt;
    logic        d_rvalid;
    logic [15:0] d_rdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_data_in;
    logic [15:0] mem_data_out;
    logic [3:0]  busy;
    logic        err;

    modport slave (
        input  i_rd, i_wr, i_addr, i_data, i_lock,
        input  d_rd, d_wr, d_addr, d_data, d_lock,
        input  mem_data_out, busy,
        output i_gnt, i_rvalid, i_rdata,
        output d_gnt, d_rvalid, d_rdata,
        output mem_rd, mem_wr, mem_addr, mem_data_in, err
    );

    modport master (
        output i_rd, i_wr, i_addr, i_data, i_lock,
        output d_rd, d_wr, d_addr, d_data, d_lock,
        output mem_data_out, busy,
        input  i_gnt, i_rvalid, i_rdata,
        input  d_gnt, d_rvalid, d_rdata,
        input  mem_rd, mem_wr, mem_addr, mem_data_in, err
    );
endinterface

// File: rtl/mem_arb.sv
// Two-requester (I/D) memory arbiter with lock ownership and 2-cycle read return.
// Define ARB_RR_EN for round-robin ties; otherwise ties always go to the D side.
module mem_arb (
    input  logic      clk,
    input  logic      rst,
    mem_arb_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, LOCK_I, LOCK_D} own_e;

    own_e       state_q, state_d;
    logic       last_q, last_d;
    logic [1:0] p1_q, p1_d;
    logic [1:0] p2_q;
    logic       i_ok, d_ok;
    logic       gnt_i, gnt_d;
    logic       rd_issue;

    always_comb begin
        i_ok = (bus.i_rd ^ bus.i_wr) && !bus.busy[bus.i_addr[2:1]]
               && (state_q != LOCK_D);
        d_ok = (bus.d_rd ^ bus.d_wr) && !bus.busy[bus.d_addr[2:1]]
               && (state_q != LOCK_I);
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (!rst) begin
            if (i_ok && d_ok) begin
`ifdef ARB_RR_EN
                gnt_i = last_q;
                gnt_d = !last_q;
`else
                gnt_d = 1'b1;
`endif
            end else begin
                gnt_i = i_ok;
                gnt_d = d_ok;
            end
        end
    end

    always_comb begin
        bus.mem_rd      = 1'b0;
        bus.mem_wr      = 1'b0;
        bus.mem_addr    = 16'h0000;
        bus.mem_data_in = 16'h0000;
        unique case (1'b1)
            gnt_i: begin
                bus.mem_rd      = bus.i_rd;
                bus.mem_wr      = bus.i_wr;
                bus.mem_addr    = bus.i_addr;
                bus.mem_data_in = bus.i_data;
            end
            gnt_d: begin
                bus.mem_rd      = bus.d_rd;
                bus.mem_wr      = bus.d_wr;
                bus.mem_addr    = bus.d_addr;
                bus.mem_data_in = bus.d_data;
            end
            default: ;
        endcase
    end

    assign rd_issue = (gnt_i & bus.i_rd) | (gnt_d & bus.d_rd);

    // last_q: 1 = D side won most recently
    always_comb begin
        state_d = state_q;
        last_d  = last_q;
        p1_d    = {rd_issue, gnt_d};
        if (gnt_i || gnt_d)
            last_d = gnt_d;
        unique case (state_q)
            IDLE: begin
                if (gnt_i && bus.i_lock)
                    state_d = LOCK_I;
                else if (gnt_d && bus.d_lock)
                    state_d = LOCK_D;
            end
            LOCK_I:  if (!bus.i_lock) state_d = IDLE;
            LOCK_D:  if (!bus.d_lock) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            last_q  <= 1'b1;
            p1_q    <= 2'b00;
            p2_q    <= 2'b00;
        end else begin
            state_q <= state_d;
            last_q  <= last_d;
            p1_q    <= p1_d;
            p2_q    <= p1_q;
        end
    end

    assign bus.i_gnt    = gnt_i;
    assign bus.d_gnt    = gnt_d;
    assign bus.i_rvalid = p2_q[1] & !p2_q[0];
    assign bus.d_rvalid = p2_q[1] & p2_q[0];
    assign bus.i_rdata  = bus.mem_data_out;
    assign bus.d_rdata  = bus.mem_data_out;
    assign bus.err      = !rst & ((bus.i_rd & bus.i_wr) | (bus.d_rd & bus.d_wr));
endmodule

// File: tb/tb_mem_arb.sv
// Directed + random bench for mem_arb against a cycle-level reference model.
// Define ARB_RR_EN here too when building the round-robin variant.
module tb_mem_arb;
    logic clk = 1'b0;
    logic rst;
    mem_arb_if bus();

    mem_arb dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int ncmp = 0;
    int nerr = 0;

    // model: owner 0=none 1=I 2=D; last 1=I 2=D; h1/h2 = read issuer 1/2 cycles ago
    int owner, last, h1, h2;
    int gi_cnt, gd_cnt, ri_cnt, rd_cnt, err_cnt;
    int seq;

    task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        owner = 0;
        last  = 2;
        h1    = 0;
        h2    = 0;
    endtask

    task automatic idle_in();
        bus.i_rd = 0; bus.i_wr = 0; bus.i_addr = 0; bus.i_data = 0;
        bus.i_lock = 0;
        bus.d_rd = 0; bus.d_wr = 0; bus.d_addr = 0; bus.d_data = 0;
        bus.d_lock = 0;
        bus.busy = 0;
        bus.mem_data_out = 0;
    endtask

    function automatic bit side_ok(int s);
        logic r, w;
        logic [15:0] a;
        r = (s == 1) ? bus.i_rd : bus.d_rd;
        w = (s == 1) ? bus.i_wr : bus.d_wr;
        a = (s == 1) ? bus.i_addr : bus.d_addr;
        return (r != w) && (bus.busy[(a >> 1) & 3] == 1'b0)
               && (owner == 0 || owner == s);
    endfunction

    function automatic int pick();
        bit oi, od;
        oi = side_ok(1);
        od = side_ok(2);
        if (oi && od) begin
`ifdef ARB_RR_EN
            return (last == 2) ? 1 : 2;
`else
            return 2;
`endif
        end
        if (oi) return 1;
        if (od) return 2;
        return 0;
    endfunction

    // One clock: inputs already set; check at negedge, advance model at posedge.
    task automatic cycle();
        int w;
        logic erd, ewr, elk, ee;
        logic [15:0] ea, ed;
        @(negedge clk);
        w   = rst ? 0 : pick();
        erd = 0; ewr = 0; ea = 0; ed = 0; elk = 0;
        if (w == 1) begin
            erd = bus.i_rd; ewr = bus.i_wr; ea = bus.i_addr;
            ed = bus.i_data; elk = bus.i_lock;
        end else if (w == 2) begin
            erd = bus.d_rd; ewr = bus.d_wr; ea = bus.d_addr;
            ed = bus.d_data; elk = bus.d_lock;
        end
        ee = !rst && ((bus.i_rd && bus.i_wr) || (bus.d_rd && bus.d_wr));
        chk("i_gnt", bus.i_gnt, w == 1);
        chk("d_gnt", bus.d_gnt, w == 2);
        chk("mem_rd", bus.mem_rd, erd);
        chk("mem_wr", bus.mem_wr, ewr);
        chk("mem_addr", bus.mem_addr, ea);
        chk("mem_wdata", bus.mem_data_in, ed);
        chk("err", bus.err, ee);
        chk("i_rvalid", bus.i_rvalid, h2 == 1);
        chk("d_rvalid", bus.d_rvalid, h2 == 2);
        chk("i_rdata", bus.i_rdata, bus.mem_data_out);
        chk("d_rdata", bus.d_rdata, bus.mem_data_out);
        gi_cnt  += int'(bus.i_gnt);
        gd_cnt  += int'(bus.d_gnt);
        ri_cnt  += int'(bus.i_rvalid);
        rd_cnt  += int'(bus.d_rvalid);
        err_cnt += int'(bus.err);
        seq = seq * 4 + (bus.i_gnt ? 1 : 0) + (bus.d_gnt ? 2 : 0);
        @(posedge clk);
        if (!rst) begin
            h2 = h1;
            h1 = (w != 0 && erd) ? w : 0;
            if (w != 0) last = w;
            if (owner == 0) begin
                if (w != 0 && elk) owner = w;
            end else if (!((owner == 1) ? bus.i_lock : bus.d_lock)) begin
                owner = 0;
            end
        end
        #1;
    endtask

    task automatic do_reset(int n);
        rst = 1;
        model_reset();
        repeat (n) cycle();
        rst = 0;
    endtask

    initial begin
        int g0, r0, e0;
        logic [15:0] v;
        gi_cnt = 0; gd_cnt = 0; ri_cnt = 0; rd_cnt = 0; err_cnt = 0;
        seq = 0;
        idle_in();
        model_reset();
        rst = 1;
        @(posedge clk);
        #1;
        do_reset(2);

        // single I read, return two cycles later
        bus.i_rd = 1; bus.i_addr = 16'h0010;
        cycle();
        chk("r33_gnt", 16'(gi_cnt), 16'd1);
        idle_in();
        bus.mem_data_out = 16'h5A5A;
        cycle();
        cycle();
        chk("r33_ivld", 16'(ri_cnt), 16'd1);
        chk("r33_dvld", 16'(rd_cnt), 16'd0);

        // held tie, different banks
        do_reset(1);
        bus.i_rd = 1; bus.i_addr = 16'h0002;
        bus.d_rd = 1; bus.d_addr = 16'h0004;
        seq = 0;
        repeat (4) cycle();
`ifdef ARB_RR_EN
        chk("r34_seq", 16'(seq), 16'h0066);
`else
        chk("r34_seq", 16'(seq), 16'h00AA);
`endif
        idle_in();
        cycle();
        cycle();

        // D locked burst while I waits
        do_reset(1);
        g0 = gi_cnt;
        e0 = gd_cnt;
        bus.d_rd = 1; bus.d_lock = 1; bus.d_addr = 16'h0000;
        cycle();
        bus.i_rd = 1; bus.i_addr = 16'h0010;
        bus.d_addr = 16'h0002; cycle();
        bus.d_addr = 16'h0004; cycle();
        bus.d_addr = 16'h0006; bus.d_lock = 0; cycle();
        chk("r35_dgnt", 16'(gd_cnt - e0), 16'd4);
        chk("r35_igntl", 16'(gi_cnt - g0), 16'd0);
        bus.d_rd = 0;
        cycle();
        chk("r35_igntr", 16'(gi_cnt - g0), 16'd1);
        idle_in();
        cycle();
        cycle();

        // write held off by busy bank
        g0 = gi_cnt;
        r0 = ri_cnt;
        bus.i_wr = 1; bus.i_addr = 16'h0004; bus.i_data = 16'hBEEF;
        bus.busy = 4'b0100;
        cycle();
        chk("r36_blk", 16'(gi_cnt - g0), 16'd0);
        bus.busy = 4'b0000;
        cycle();
        chk("r36_gnt", 16'(gi_cnt - g0), 16'd1);
        idle_in();
        cycle();
        cycle();
        chk("r36_norv", 16'(ri_cnt - r0), 16'd0);

        // illegal rd+wr on D, I still served
        g0 = gi_cnt;
        e0 = err_cnt;
        bus.d_rd = 1; bus.d_wr = 1; bus.d_addr = 16'h0008;
        bus.i_rd = 1; bus.i_addr = 16'h0020;
        cycle();
        chk("r37_err", 16'(err_cnt - e0), 16'd1);
        chk("r37_ign", 16'(gi_cnt - g0), 16'd1);
        idle_in();
        cycle();
        cycle();

        // reset with a read in flight
        r0 = ri_cnt + rd_cnt;
        bus.i_rd = 1; bus.i_addr = 16'h0000;
        cycle();
        idle_in();
        do_reset(1);
        cycle();
        cycle();
        cycle();
        chk("r38_norv", 16'(ri_cnt + rd_cnt - r0), 16'd0);
        bus.i_rd = 1; bus.i_addr = 16'h0002;
        bus.d_rd = 1; bus.d_addr = 16'h0004;
        seq = 0;
        cycle();
`ifdef ARB_RR_EN
        chk("r38_last", 16'(seq), 16'd1);
`else
        chk("r38_last", 16'(seq), 16'd2);
`endif
        idle_in();
        cycle();
        cycle();

        // random traffic
        for (int n = 0; n < 600; n++) begin
            v = 16'($urandom);
            bus.i_rd = v[0]; bus.i_wr = v[1] & (v[2] | v[3]);
            bus.d_rd = v[4]; bus.d_wr = v[5] & (v[6] | v[7]);
            bus.i_lock = (v[10:8] == 0);
            bus.d_lock = (v[13:11] == 0);
            bus.i_addr = 16'($urandom);
            bus.d_addr = 16'($urandom);
            bus.i_data = 16'($urandom);
            bus.d_data = 16'($urandom);
            bus.busy = 4'($urandom) & 4'($urandom);
            bus.mem_data_out = 16'($urandom);
            if ($urandom_range(0, 79) == 0)
                do_reset(1);
            else
                cycle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule
